aes_dec_unit: RTL and testbench
===============================

// Module: aes_dec_unit
// PURPOSE
//  Multi-cycle AES decrypt-direction byte unit for aes32dsi / aes32dsmi.
//  - Selects one byte of rs2, applies InvSubBytes, and optionally applies the InvMixColumn column
//    product {0b,0d,09,0e}.
//  - Rotates the result by the byte select and XORs it into rs1.
//  - Sits beside the forward AES unit in the crypto ALU.
//  - Registered: issue/complete handshake towards the Ibex multi-cycle ALU.
// PARAMETERS
//  LOGIC_GATING  0  1: AND rs1/rs2 captures with valid_in&ready_out to cut toggling
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   asynchronous active-low reset
//  valid_in      in   1   operands valid; accepted when valid_in & ready_out
//  ready_out     out  1   unit idle, can accept
//  rs1_in        in   32  source register 1 (XOR accumulator)
//  rs2_in        in   32  source register 2 (byte source)
//  bs_in         in   2   byte select immediate
//  mix_in        in   1   1: aes32dsmi (InvSub+InvMix), 0: aes32dsi (InvSub only)
//  kill_in       in   1   abort operation in flight (pipeline flush)
//  rd_valid_out  out  1   rd_out valid; held until rd_ack_in
//  rd_ack_in     in   1   consumer takes result
//  rd_out        out  32  result
// BEHAVIOUR
//  Reset: state IDLE; ready_out=1, rd_valid_out=0, rd_out=0; all datapath regs 0.
//  Accept in IDLE on valid_in:
//   - Register rs1, bs, mix, and byte rs2[8*bs+:8]; go to SBOX.
//  SBOX (1 cycle):
//   - Register s = InvSbox(byte).
//   - mix=0: go to DONE.
//   - mix=1: go to MIX.
//  MIX: GF(2^8) products with reduction poly 0x11b.
//   - Column = {0b*s, 0d*s, 09*s, 0e*s} in bits [31:24] .. [7:0].
//   - Non-mix column = {24'b0, s}.
//  DONE:
//   - rd_out = rotl(column, 8*bs) ^ rs1; rd_valid_out=1.
//   - Stay in DONE until rd_ack_in, then go to IDLE; ready_out=1 next cycle.
//  Handshakes:
//   - ready_out=1 only in IDLE; valid_in in any other state is ignored.
//   - No back-to-back accept in the ack cycle.
//  Latency, accept to rd_valid_out:
//   - mix=0: 2 cycles.
//   - mix=1: 3 cycles (MIX is 1 cycle).
//   - mix=1 with AES_DEC_SERIAL_MIX_EN: 6 cycles (MIX is 4 cycles).
//  rd_out keeps its last value outside DONE; it is meaningful only while rd_valid_out=1.
//  kill_in (any non-IDLE state, including DONE):
//   - Next state IDLE; rd_valid_out=0.
//   - kill_in wins over rd_ack_in.
//   - kill_in in IDLE with valid_in: no accept, stays IDLE.
//  Async reset mid-operation: immediately back to reset values; no result is produced.
//  bs=0 gives no rotation; bs=3 rotates left by 24.
// CONFIGURATION
//  AES_DEC_SERIAL_MIX_EN:
//   - Defined: one shared GF multiplier; MIX lasts 4 cycles.
//   - 2-bit counter steps 0..3, producing the 0e, 09, 0d, 0b lanes into a 32-bit accumulator.
//   - Counter clears on entry to MIX, on kill_in, and on reset.
//   - Undefined: all four products in 1 MIX cycle.
//   - rd_out values are identical either way.
// TESTING
//  - Reset: assert rst_ni=0 mid-MIX -> ready_out=1, rd_valid_out=0, rd_out=0 at once.
//  - dsi: rs1=0, rs2=0x00000063, bs=0, mix=0 -> rd_out=0x00000000, 2 cycles after accept.
//  - dsi: rs1=0xFFFFFFFF, rs2=0, bs=0, mix=0 -> rd_out=0xFFFFFFAD.
//  - dsmi: rs1=0, rs2=0, bs=0, mix=1 -> rd_out=0x50A7F451 (3 cycles; 6 with serial macro).
//  - dsmi: rs1=0, rs2=0x63630063, bs=1, mix=1 -> rd_out=0xA7F45150.
//  - Backpressure/kill:
//    - Hold rd_ack_in=0 for 5 cycles -> rd_out stable, ready_out=0, extra valid_in ignored.
//    - kill_in with rd_ack_in=1 in DONE -> IDLE, no result accepted.

Source files
------------

// File: rtl/aes_dec_unit.sv
// aes_dec_unit: multi-cycle AES decrypt-direction byte unit for aes32dsi / aes32dsmi.
// Picks one byte of rs2, applies InvSubBytes, optionally forms the InvMixColumns
// column {0b,0d,09,0e}*s, rotates it by the byte select and XORs it into rs1.
// Build macro AES_DEC_SERIAL_MIX_EN: when defined, MIX uses one shared GF multiplier
// over 4 cycles instead of four parallel products in a single cycle.
module aes_dec_unit #(
  parameter bit LOGIC_GATING = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  bs_in,
  input  logic        mix_in,
  input  logic        kill_in,
  output logic        rd_valid_out,
  input  logic        rd_ack_in,
  output logic [31:0] rd_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SBOX = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Rotate a word left by whole bytes.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] x, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = x;
      2'd1:    r = {x[23:0], x[31:24]};
      2'd2:    r = {x[15:0], x[31:16]};
      default: r = {x[7:0],  x[31:8]};
    endcase
    return r;
  endfunction

`ifdef AES_DEC_SERIAL_MIX_EN
  // Shared multiplier: a * c for a 4-bit constant c (all InvMix coefficients fit).
  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction
`else
  // Full InvMixColumns column for a single non-zero input byte: {0b,0d,09,0e}*s.
  function automatic logic [31:0] inv_mix_col(input logic [7:0] s);
    logic [7:0] x2, x4, x8;
    x2 = xtime(s);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x2 ^ s, x8 ^ x4 ^ s, x8 ^ s, x8 ^ x4 ^ x2};
  endfunction
`endif

  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  bs_q, bs_d;
  logic        mix_q, mix_d;
  logic [7:0]  s_q, s_d;
  logic [31:0] rd_q, rd_d;

  logic        accept;
  logic [31:0] rs1_g;
  logic [31:0] rs2_g;
  logic [7:0]  sbox_out;

`ifdef AES_DEC_SERIAL_MIX_EN
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  lane_coef;
  logic [7:0]  lane_prod;

  // Lane order 0e, 09, 0d, 0b fills the accumulator from byte 0 upwards.
  always_comb begin
    case (cnt_q)
      2'd0:    lane_coef = 4'he;
      2'd1:    lane_coef = 4'h9;
      2'd2:    lane_coef = 4'hd;
      default: lane_coef = 4'hb;
    endcase
  end

  assign lane_prod = gf_mul4(s_q, lane_coef);
`endif

  assign ready_out    = (state_q == ST_IDLE);
  assign rd_valid_out = (state_q == ST_DONE);
  assign rd_out       = rd_q;

  // A kill in IDLE blocks the accept outright.
  assign accept   = valid_in & ready_out & ~kill_in;
  assign sbox_out = INV_SBOX[byte_q];

  // Optional operand gating so the capture muxes only toggle on a real accept.
  if (LOGIC_GATING) begin : g_gate
    assign rs1_g = rs1_in & {32{accept}};
    assign rs2_g = rs2_in & {32{accept}};
  end else begin : g_nogate
    assign rs1_g = rs1_in;
    assign rs2_g = rs2_in;
  end

  // Next-state and datapath update for the IDLE -> SBOX -> (MIX) -> DONE sequence.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    byte_d  = byte_q;
    bs_d    = bs_q;
    mix_d   = mix_q;
    s_d     = s_q;
    rd_d    = rd_q;
`ifdef AES_DEC_SERIAL_MIX_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rs1_d   = rs1_g;
          byte_d  = rs2_g[{bs_in, 3'b000} +: 8];
          bs_d    = bs_in;
          mix_d   = mix_in;
          state_d = ST_SBOX;
        end
      end
      ST_SBOX: begin
        s_d = sbox_out;
        if (mix_q) begin
          state_d = ST_MIX;
`ifdef AES_DEC_SERIAL_MIX_EN
          cnt_d   = 2'd0;
          acc_d   = 32'h0;
`endif
        end else begin
          rd_d    = rotl_bytes({24'h0, sbox_out}, bs_q) ^ rs1_q;
          state_d = ST_DONE;
        end
      end
      ST_MIX: begin
`ifdef AES_DEC_SERIAL_MIX_EN
        acc_d[{cnt_q, 3'b000} +: 8] = lane_prod;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          rd_d    = rotl_bytes({lane_prod, acc_q[23:0]}, bs_q) ^ rs1_q;
          state_d = ST_DONE;
        end
`else
        rd_d    = rotl_bytes(inv_mix_col(s_q), bs_q) ^ rs1_q;
        state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (rd_ack_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including an ack in DONE; the old result stays put.
    if (kill_in && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rd_d    = rd_q;
`ifdef AES_DEC_SERIAL_MIX_EN
      cnt_d   = 2'd0;
`endif
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rs1_q   <= 32'h0;
      byte_q  <= 8'h0;
      bs_q    <= 2'd0;
      mix_q   <= 1'b0;
      s_q     <= 8'h0;
      rd_q    <= 32'h0;
`ifdef AES_DEC_SERIAL_MIX_EN
      cnt_q   <= 2'd0;
      acc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      byte_q  <= byte_d;
      bs_q    <= bs_d;
      mix_q   <= mix_d;
      s_q     <= s_d;
      rd_q    <= rd_d;
`ifdef AES_DEC_SERIAL_MIX_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_dec_unit.sv
// tb_aes_dec_unit: randomized self-checking bench for aes_dec_unit against a
// GF(2^8)-arithmetic reference model (S-box derived from inversion + affine map).
module tb_aes_dec_unit;

`ifdef AES_DEC_SERIAL_MIX_EN
  localparam int LAT_MIX = 6;
`else
  localparam int LAT_MIX = 3;
`endif
  localparam int LAT_SUB = 2;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  bs;
  logic        mix;
  logic        kill;
  logic        rd_valid;
  logic        rd_ack;
  logic [31:0] rd;

  int tests_run;
  int tests_failed;

  logic [7:0] inv_tbl [256];

  aes_dec_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_in    (valid),
    .ready_out   (ready),
    .rs1_in      (rs1),
    .rs2_in      (rs2),
    .bs_in       (bs),
    .mix_in      (mix),
    .kill_in     (kill),
    .rd_valid_out(rd_valid),
    .rd_ack_in   (rd_ack),
    .rd_out      (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Schoolbook polynomial product followed by reduction modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  // Forward S-box = affine(inverse(x)); the inverse table is its permutation inverse.
  task automatic build_tables();
    logic [7:0] inv, fwd;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tbl[fwd] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s, input logic m);
    logic [7:0]  sel, sb;
    logic [31:0] col, w;
    logic [63:0] t;
    w   = b >> (8 * int'(s));
    sel = w[7:0];
    sb  = inv_tbl[sel];
    col = m ? {gmul(sb, 8'h0b), gmul(sb, 8'h0d), gmul(sb, 8'h09), gmul(sb, 8'h0e)}
            : {24'h0, sb};
    t = {col, col} << (8 * int'(s));
    return t[63:32] ^ a;
  endfunction

  // Issue one operation at a negedge and wait (bounded) for rd_valid; lat counts
  // cycles from the accept cycle (0) to the first cycle with rd_valid high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                        input logic m, output int lat, output logic [31:0] res);
    rs1 = a; rs2 = b; bs = s; mix = m; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (rd_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = rd;
  endtask

  task automatic do_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_idle ready=%b rd_valid=%b exp 1/0", ready, rd_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] a_t [4] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] b_t [4] = '{32'h00000063, 32'h0, 32'h0, 32'h63630063};
    logic [1:0]  s_t [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic        m_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_t [4] = '{32'h00000000, 32'hFFFFFFAD, 32'h50A7F451, 32'hA7F45150};
    int lat, exp_lat;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], s_t[i], m_t[i], lat, res);
      exp_lat = m_t[i] ? LAT_MIX : LAT_SUB;
      $display("[TB] directed %0d rs1=%h rs2=%h bs=%0d mix=%b rd=%h lat=%0d", i, a_t[i], b_t[i], s_t[i], m_t[i], res, lat);
      tests_run++; if (res !== e_t[i]) begin tests_failed++; $display("FAIL dir_rd[%0d] got=%h exp=%h", i, res, e_t[i]); end
      tests_run++; if (lat != exp_lat) begin tests_failed++; $display("FAIL dir_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
      do_ack();
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [31:0] a, b, res, exp;
    logic [1:0] s;
    logic m;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; s = 2'($urandom_range(0, 3)); m = 1'($urandom_range(0, 1));
      exp = model(a, b, s, m);
      exp_lat = m ? LAT_MIX : LAT_SUB;
      run_op(a, b, s, m, lat, res);
      $display("[TB] random %0d rs1=%h rs2=%h bs=%0d mix=%b rd=%h lat=%0d", i, a, b, s, m, res, lat);
      tests_run++; if (res !== exp) begin tests_failed++; $display("FAIL rnd_rd[%0d] got=%h exp=%h", i, res, exp); end
      tests_run++; if (lat != exp_lat) begin tests_failed++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_ack();
      tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0) begin
        tests_failed++; $display("FAIL rnd_after_ack[%0d] ready=%b rd_valid=%b exp 1/0", i, ready, rd_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] res, exp, exp2, a2, b2;
    a2 = $urandom; b2 = $urandom;
    exp  = model(32'hDEADBEEF, 32'h12345678, 2'd2, 1'b1);
    exp2 = model(a2, b2, 2'd3, 1'b1);
    run_op(32'hDEADBEEF, 32'h12345678, 2'd2, 1'b1, lat, res);
    $display("[TB] backpressure rd=%h lat=%0d", res, lat);
    for (int c = 0; c < 5; c++) begin
      rs1 = a2; rs2 = b2; bs = 2'd3; mix = 1'b1; valid = 1'b1;
      @(negedge clk);
      tests_run++; if (rd !== exp || rd_valid !== 1'b1 || ready !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold[%0d] rd=%h valid=%b ready=%b exp %h/1/0", c, rd, rd_valid, ready, exp);
      end
    end
    valid = 1'b0;
    do_ack();
    run_op(a2, b2, 2'd3, 1'b1, lat, res);
    $display("[TB] after backpressure rd=%h lat=%0d", res, lat);
    tests_run++; if (res !== exp2) begin tests_failed++; $display("FAIL bp_next_rd got=%h exp=%h", res, exp2); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res, exp, a, b;
    a = $urandom; b = $urandom;
    exp = model(a, b, 2'd1, 1'b0);
    run_op(32'h0BADF00D, 32'h00C0FFEE, 2'd0, 1'b0, lat, res);
    rs1 = a; rs2 = b; bs = 2'd1; mix = 1'b0; valid = 1'b1; rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_no_accept ready=%b rd_valid=%b exp 1/0", ready, rd_valid);
    end
    run_op(a, b, 2'd1, 1'b0, lat, res);
    $display("[TB] back-to-back rs1=%h rs2=%h rd=%h lat=%0d", a, b, res, lat);
    tests_run++; if (res !== exp) begin tests_failed++; $display("FAIL b2b_rd got=%h exp=%h", res, exp); end
    tests_run++; if (lat != LAT_SUB) begin tests_failed++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, LAT_SUB); end
    do_ack();
  endtask

  task automatic test_kill();
    int lat, seen;
    logic [31:0] res, exp, a, b;
    // kill in IDLE blocks the accept
    rs1 = $urandom; rs2 = $urandom; bs = 2'd0; mix = 1'b0; valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid = 1'b0; kill = 1'b0;
    seen = 0;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL kill_idle_ready got=%b exp=1", ready); end
    repeat (8) begin @(negedge clk); if (rd_valid === 1'b1) seen++; end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL kill_idle_result got=%0d exp=0", seen); end
    $display("[TB] kill in IDLE, result cycles=%0d", seen);
    // kill in SBOX and in MIX
    for (int k = 1; k <= 2; k++) begin
      rs1 = $urandom; rs2 = $urandom; bs = 2'd2; mix = 1'b1; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      if (k == 2) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0) begin
        tests_failed++; $display("FAIL kill_busy[%0d] ready=%b rd_valid=%b exp 1/0", k, ready, rd_valid);
      end
      seen = 0;
      repeat (8) begin @(negedge clk); if (rd_valid === 1'b1) seen++; end
      tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL kill_busy_result[%0d] got=%0d exp=0", k, seen); end
      $display("[TB] kill at cycle %0d, result cycles=%0d", k, seen);
    end
    // unit still correct after a kill mid-MIX
    a = $urandom; b = $urandom;
    exp = model(a, b, 2'd2, 1'b1);
    run_op(a, b, 2'd2, 1'b1, lat, res);
    tests_run++; if (res !== exp) begin tests_failed++; $display("FAIL kill_recover_rd got=%h exp=%h", res, exp); end
    tests_run++; if (lat != LAT_MIX) begin tests_failed++; $display("FAIL kill_recover_lat got=%0d exp=%0d", lat, LAT_MIX); end
    // kill beats ack in DONE
    kill = 1'b1; rd_ack = 1'b1;
    @(negedge clk);
    kill = 1'b0; rd_ack = 1'b0;
    tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL kill_done ready=%b rd_valid=%b exp 1/0", ready, rd_valid);
    end
    $display("[TB] kill+ack in DONE rd=%h", res);
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] res, exp, a, b;
    a = 32'hDEADBEEF; b = $urandom;
    exp = model(a, b, 2'd1, 1'b0);
    run_op(a, b, 2'd1, 1'b0, lat, res);
    do_ack();
    tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL pre_reset_rd got=%h exp=%h", rd, exp); end
    rs1 = $urandom; rs2 = $urandom; bs = 2'd3; mix = 1'b1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (ready !== 1'b1 || rd_valid !== 1'b0 || rd !== 32'h0) begin
      tests_failed++; $display("FAIL async_reset ready=%b rd_valid=%b rd=%h exp 1/0/00000000", ready, rd_valid, rd);
    end
    $display("[TB] async reset mid-MIX ready=%b rd=%h", ready, rd);
    @(negedge clk);
    rst_n = 1'b1;
    a = $urandom; b = $urandom;
    exp = model(a, b, 2'd3, 1'b1);
    run_op(a, b, 2'd3, 1'b1, lat, res);
    tests_run++; if (res !== exp) begin tests_failed++; $display("FAIL post_async_rd got=%h exp=%h", res, exp); end
    do_ack();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    valid = 1'b0; rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0; mix = 1'b0; kill = 1'b0; rd_ack = 1'b0;
    build_tables();
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
